// File: rtl/round_robin_arb_pkg.sv
// Shared definitions for the round-robin stream arbiter.
//   STAT_W   : width of each per-requester grant counter (optional statistics).
//   id_width : width of a requester index, never less than one bit so that a
//              single-requester build still has a legal down_id port.
package round_robin_arb_pkg;

  localparam int STAT_W = 16;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin grant selection.
// Scans req starting at ptr and wrapping modulo n_req; the first set request
// wins. The wrap is done by scanning a doubled copy of the request vector, so
// positions ptr .. ptr+n_req-1 of {req, req} cover every requester once.
// Ports:
//   req       : per-requester request (upstream valid)
//   ptr       : requester with highest priority this cycle (0 .. n_req-1)
//   grant     : one-hot grant, all zero when nothing requests
//   index     : binary index of the granted requester (0 when none)
//   any_grant : at least one requester was granted
module rr_grant_select #(
  parameter int n_req = 3,
  parameter int id_w  = 2
) (
  input  logic [n_req-1:0] req,
  input  logic [id_w-1:0]  ptr,
  output logic [n_req-1:0] grant,
  output logic [id_w-1:0]  index,
  output logic             any_grant
);

  logic [2*n_req-1:0] dbl;

  always_comb begin
    dbl       = {req, req};
    grant     = '0;
    index     = '0;
    any_grant = 1'b0;
    for (int k = 0; k < n_req; k++) begin
      int pos;
      pos = int'(ptr) + k;
      if (!any_grant && dbl[pos]) begin
        any_grant = 1'b1;
        // Fold the doubled-vector position back into 0 .. n_req-1.
        if (pos >= n_req) index = id_w'(pos - n_req);
        else              index = id_w'(pos);
      end
    end
    if (any_grant) grant[index] = 1'b1;
  end

endmodule

// File: rtl/round_robin_stream_arbiter.sv
// Round-robin arbiter merging n_req valid/ready streams into one output
// stream through a single registered output stage (1-cycle latency, one beat
// per cycle sustained). Each output beat carries the index of its source.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holds valid and data stable until it sees ready; ready may
// depend combinationally on the consumer's ready but valid never depends on
// ready.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   up_valid    : per-requester valid
//   up_ready    : per-requester ready (only the granted requester, and only
//                 when the output register can load)
//   up_data     : flattened data, requester i at [i*width +: width]
//   down_valid  : output beat valid
//   down_ready  : consumer ready
//   down_data   : output beat data
//   down_id     : source requester of the current beat
//   grant_count : present only with ROUND_ROBIN_STREAM_ARBITER_STATS_EN defined;
//                 saturating per-requester handshake counters, flattened
//                 like up_data with STAT_W bits each
module round_robin_stream_arbiter
  import round_robin_arb_pkg::*;
#(
  parameter int n_req = 3,
  parameter int width = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [n_req-1:0]             up_valid,
  output logic [n_req-1:0]             up_ready,
  input  logic [n_req*width-1:0]       up_data,
  output logic                         down_valid,
  input  logic                         down_ready,
  output logic [width-1:0]             down_data,
  output logic [id_width(n_req)-1:0]   down_id
`ifdef ROUND_ROBIN_STREAM_ARBITER_STATS_EN
  ,
  output logic [n_req*STAT_W-1:0]      grant_count
`endif
);

  localparam int ID_W = id_width(n_req);

  logic              load;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [ID_W-1:0]   gidx;
  logic [n_req-1:0]  grant;
  logic              any_grant;
  logic [width-1:0]  sel_data;

  // The output register accepts a new beat when empty or draining this cycle.
  assign load = ~down_valid | down_ready;

  rr_grant_select #(
    .n_req (n_req),
    .id_w  (ID_W)
  ) u_grant_select (
    .req       (up_valid),
    .ptr       (ptr),
    .grant     (grant),
    .index     (gidx),
    .any_grant (any_grant)
  );

  assign up_ready = grant & {n_req{load}};

  always_comb begin
    sel_data = up_data[int'(gidx)*width +: width];
    // Priority moves to the requester after the winner, wrapping to 0.
    if (int'(gidx) == n_req - 1) ptr_next = '0;
    else                         ptr_next = gidx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_id    <= '0;
      ptr        <= '0;
    end else if (load) begin
      if (any_grant) begin
        down_valid <= 1'b1;
        down_data  <= sel_data;
        down_id    <= gidx;
        ptr        <= ptr_next;
      end else begin
        // Empty slot: data/id keep their last values, pointer unchanged.
        down_valid <= 1'b0;
      end
    end
  end

`ifdef ROUND_ROBIN_STREAM_ARBITER_STATS_EN
  for (genvar i = 0; i < n_req; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (up_valid[i] && up_ready[i] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign grant_count[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule
